// File: rtl/alu_seq.sv
// Multi-cycle integer ALU: single-cycle logic/arith ops, shift-add multiply and
// optional restoring divide (enabled by defining ALU_DIV_EN), behind valid/ready.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             i_CLK,
  input  logic             i_RST_n,
  input  logic             i_Valid,
  output logic             o_Ready,
  input  logic [WIDTH-1:0] i_SrcA,
  input  logic [WIDTH-1:0] i_SrcB,
  input  logic [3:0]       i_ALUControl,
  output logic             o_ResultValid,
  input  logic             i_ResultReady,
  output logic [WIDTH-1:0] o_ALUResult,
  output logic             o_Zero,
  output logic [1:0]       o_DbgState
);

  localparam int CNTW = $clog2(WIDTH) + 1;
  localparam int SHW  = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DONE = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;
  localparam logic [1:0] S_DIV  = 2'd3;

  // Handshake: a request is taken on a rising edge with i_Valid && o_Ready; a
  // result is consumed on a rising edge with o_ResultValid && i_ResultReady.
  logic [1:0]         state_q, state_d;
  logic               sel_hi_q, sel_hi_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;

  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               is_mul;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic               last_iter;
`ifdef ALU_DIV_EN
  logic               is_div;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   rem_diff;
  logic               rem_ge;
  logic [2*WIDTH-1:0] div_next;
`endif

  assign shamt = i_SrcB[SHW-1:0];
  assign is_mul = (i_ALUControl == 4'b1010) || (i_ALUControl == 4'b1011);
`ifdef ALU_DIV_EN
  assign is_div = (i_ALUControl == 4'b1100) || (i_ALUControl == 4'b1101);
`endif

  always_comb begin
    alu_res = '0;
    case (i_ALUControl)
      4'b0000: alu_res = i_SrcA + i_SrcB;
      4'b0001: alu_res = i_SrcA - i_SrcB;
      4'b0010: alu_res = i_SrcA & i_SrcB;
      4'b0011: alu_res = i_SrcA | i_SrcB;
      4'b0100: alu_res = i_SrcA ^ i_SrcB;
      4'b0101: alu_res = {{(WIDTH-1){1'b0}}, ($signed(i_SrcA) < $signed(i_SrcB))};
      4'b0110: alu_res = {{(WIDTH-1){1'b0}}, (i_SrcA < i_SrcB)};
      4'b0111: alu_res = i_SrcA << shamt;
      4'b1000: alu_res = i_SrcA >> shamt;
      4'b1001: alu_res = $unsigned($signed(i_SrcA) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // Multiply: acc = {partial_hi, multiplier}; add multiplicand into the high half
  // when the multiplier LSB is set, then shift the whole product right.
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
  assign last_iter = (cnt_q == CNTW'(WIDTH - 1));

`ifdef ALU_DIV_EN
  // Divide: acc = {remainder, dividend/quotient}; a zero divisor naturally
  // yields an all-ones quotient and the dividend as remainder.
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign rem_ge   = (rem_sh >= {1'b0, opnd_q});
  assign rem_diff = rem_sh[WIDTH-1:0] - opnd_q;
  assign div_next = {(rem_ge ? rem_diff : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], rem_ge};
`endif

  always_comb begin
    state_d  = state_q;
    sel_hi_d = sel_hi_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE: begin
        if (i_Valid) begin
          sel_hi_d = i_ALUControl[0];
          cnt_d    = '0;
          if (is_mul) begin
            opnd_d  = i_SrcA;
            acc_d   = {{WIDTH{1'b0}}, i_SrcB};
            state_d = S_MUL;
          end
`ifdef ALU_DIV_EN
          else if (is_div) begin
            opnd_d  = i_SrcB;
            acc_d   = {{WIDTH{1'b0}}, i_SrcA};
            state_d = S_DIV;
          end
`endif
          else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            state_d  = S_DONE;
          end
        end
      end
      S_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + 1'b1;
        if (last_iter) begin
          result_d = sel_hi_q ? mul_next[2*WIDTH-1:WIDTH] : mul_next[WIDTH-1:0];
          zero_d   = (result_d == '0);
          state_d  = S_DONE;
        end
      end
      S_DIV: begin
`ifdef ALU_DIV_EN
        acc_d = div_next;
        cnt_d = cnt_q + 1'b1;
        if (last_iter) begin
          result_d = sel_hi_q ? div_next[2*WIDTH-1:WIDTH] : div_next[WIDTH-1:0];
          zero_d   = (result_d == '0);
          state_d  = S_DONE;
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_DONE: begin
        if (i_ResultReady) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state_q  <= S_IDLE;
      sel_hi_q <= 1'b0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      sel_hi_q <= sel_hi_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign o_Ready       = (state_q == S_IDLE);
  assign o_ResultValid = (state_q == S_DONE);
  assign o_ALUResult   = result_q;
  assign o_Zero        = zero_q;
  assign o_DbgState    = state_q;

endmodule
